dsmod_mc: RTL and testbench

DSMOD_MC -- requirements
Module: dsmod_mc

---
 rtl/dsmod_mc_pkg.sv | 54 +++++
 rtl/dsmod_mc_ch.sv | 108 ++++++++++
 rtl/dsmod_mc.sv | 138 +++++++++++++
 tb/tb_dsmod_mc.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dsmod_mc_pkg.sv
// Shared types and constants for the multi-channel delta-sigma modulator:
// FSM states, OSR and order codes, counter reloads and dither LFSR settings.
package dsmod_mc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam logic [1:0] OSR_32  = 2'd0;
    localparam logic [1:0] OSR_64  = 2'd1;
    localparam logic [1:0] OSR_128 = 2'd2;
    localparam logic [1:0] OSR_256 = 2'd3;

    localparam int CNT_W = 8;

    localparam logic [CNT_W-1:0] RELOAD_32  = 8'd31;
    localparam logic [CNT_W-1:0] RELOAD_64  = 8'd63;
    localparam logic [CNT_W-1:0] RELOAD_128 = 8'd127;
    localparam logic [CNT_W-1:0] RELOAD_256 = 8'd255;

    localparam logic ORDER_1 = 1'b0;
    localparam logic ORDER_2 = 1'b1;

    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [CNT_W-1:0] osr_reload(input logic [1:0] osr);
        case (osr)
            OSR_32:  return RELOAD_32;
            OSR_64:  return RELOAD_64;
            OSR_128: return RELOAD_128;
            default: return RELOAD_256;
        endcase
    endfunction

    function automatic logic [3:0] osr_shift(input logic [1:0] osr);
        case (osr)
            OSR_32:  return 4'd5;
            OSR_64:  return 4'd6;
            OSR_128: return 4'd7;
            default: return 4'd8;
        endcase
    endfunction

    function automatic logic [15:0] rotr16(input logic [15:0] v, input int n);
        int k;
        k = n % 16;
        return (v >> k) | (v << (16 - k));
    endfunction

endpackage

// File: rtl/dsmod_mc_ch.sv
// One modulator channel: linear interpolator between fetched samples feeding
// a 1st- or 2nd-order single-bit delta-sigma loop.
module dsmod_mc_ch
    import dsmod_mc_pkg::*;
#(
    parameter int NBIT = 24
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            run,
    input  logic            load,
    input  logic            fetch,
    input  logic            miss,
    input  logic            idle,
    input  logic            mode,
    input  logic [3:0]      shift,
    input  logic [NBIT-1:0] sample,
    input  logic [7:0]      dither,
    output logic            raw
);

    localparam int IW  = NBIT + 8;
    localparam int A1W = NBIT + 10;
    localparam int A2W = NBIT + 12;

    // Feedback magnitude equals interpolator full scale, 2^(NBIT+7).
    localparam logic signed [A1W-1:0] FB1 = {2'b00, 1'b1, {(IW-1){1'b0}}};
    localparam logic signed [A2W-1:0] FB2 = {4'b0000, 1'b1, {(IW-1){1'b0}}};

    logic signed [IW-1:0]  interp;
    logic signed [IW-1:0]  target;
    logic signed [IW-1:0]  step;
    logic signed [IW-1:0]  sample_ext;
    logic signed [IW-1:0]  step_nx;
    logic signed [IW:0]    diff;
    logic signed [IW:0]    mod_in;
    logic signed [A1W-1:0] accu1;
    logic signed [A1W-1:0] accu1_nx;
    logic signed [A1W-1:0] in1;
    logic signed [A2W-1:0] accu2;
    logic signed [A2W-1:0] accu3;
    logic signed [A2W-1:0] accu2_nx;
    logic signed [A2W-1:0] accu3_nx;
    logic signed [A2W-1:0] in2;
    logic                  raw_int;

    assign sample_ext = {sample, 8'h00};
    assign diff       = {sample_ext[IW-1], sample_ext} - {target[IW-1], target};
    assign step_nx    = IW'(diff >>> shift);
    assign mod_in     = {interp[IW-1], interp} + {{(IW-7){dither[7]}}, dither};
    assign in1        = {{(A1W-IW-1){mod_in[IW]}}, mod_in};
    assign in2        = {{(A2W-IW-1){mod_in[IW]}}, mod_in};

    // NOTE: every always_comb output gets a value on every path so no latch is inferred.
    always_comb begin
        raw_int  = (mode == ORDER_2) ? ~accu3[A2W-1] : ~accu1[A1W-1];
        accu1_nx = raw_int ? (accu1 + in1 - FB1) : (accu1 + in1 + FB1);
        accu2_nx = raw_int ? (accu2 + in2 - FB2) : (accu2 + in2 + FB2);
        accu3_nx = raw_int ? (accu3 + accu2_nx - FB2) : (accu3 + accu2_nx + FB2);
    end

    assign raw = raw_int & ~idle;

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            interp <= '0;
            target <= '0;
            step   <= '0;
            accu1  <= '0;
            accu2  <= '0;
            accu3  <= '0;
        end else if (clear) begin
            interp <= '0;
            target <= '0;
            step   <= '0;
            accu1  <= '0;
            accu2  <= '0;
            accu3  <= '0;
        end else begin
            if (load) begin
                target <= sample_ext;
                interp <= sample_ext;
                step   <= '0;
            end else if (fetch) begin
                target <= sample_ext;
                interp <= target;
                step   <= step_nx;
            end else if (miss) begin
                interp <= target;
                step   <= '0;
            end else if (run) begin
                interp <= interp + step;
            end

            if (run) begin
                if (mode == ORDER_2) begin
                    accu2 <= accu2_nx;
                    accu3 <= accu3_nx;
                end else begin
                    accu1 <= accu1_nx;
                end
            end
        end
    end

endmodule

// File: rtl/dsmod_mc.sv
// Multi-channel delta-sigma DAC modulator: shared IDLE/PRIME/RUN sequencer and
// fetch counter driving NCH channels. Optional dither via DSMOD_MC_DITHER_EN.
module dsmod_mc
    import dsmod_mc_pkg::*;
#(
    parameter int NBIT = 24,
    parameter int NCH  = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_ena,
    input  logic                i_mode,
    input  logic [1:0]          i_osr,
    input  logic                i_out_invert,
    input  logic [NCH*NBIT-1:0] i_data,
    input  logic                i_valid,
    output logic                o_ready,
    output logic                o_underrun,
    input  logic                i_clr_underrun,
    output logic [NCH-1:0]      o_ds,
    output logic [NCH-1:0]      o_ds_n
);

    state_t           state;
    logic             mode_q;
    logic [1:0]       osr_q;
    logic [CNT_W-1:0] cnt;
    logic             underrun;
    logic             slot;
    logic             idle;
    logic             clear;
    logic             run;
    logic             load;
    logic             fetch;
    logic             miss;
    logic [3:0]       shift;
    logic [NCH*8-1:0] dither;
    logic [NCH-1:0]   raw;

    assign slot  = (state == RUN) && (cnt == '0);
    assign idle  = (state == IDLE);
    assign clear = idle || !i_ena;
    assign run   = i_ena && (state == RUN);
    assign load  = i_ena && (state == PRIME) && i_valid;
    assign fetch = i_ena && slot && i_valid;
    assign miss  = i_ena && slot && !i_valid;
    assign shift = osr_shift(osr_q);

    assign o_ready    = (state == PRIME) || slot;
    assign o_underrun = underrun;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= IDLE;
            mode_q   <= ORDER_1;
            osr_q    <= OSR_32;
            cnt      <= '0;
            underrun <= 1'b0;
        end else begin
            // A clear request overrides a miss in the same cycle.
            if (i_clr_underrun) begin
                underrun <= 1'b0;
            end else if (miss) begin
                underrun <= 1'b1;
            end

            if (!i_ena) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        mode_q <= i_mode;
                        osr_q  <= i_osr;
                        state  <= PRIME;
                    end
                    PRIME: begin
                        if (i_valid) begin
                            cnt   <= osr_reload(osr_q);
                            state <= RUN;
                        end
                    end
                    RUN: begin
                        if (cnt == '0) begin
                            cnt <= osr_reload(osr_q);
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef DSMOD_MC_DITHER_EN
    logic [15:0] lfsr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            lfsr <= LFSR_SEED;
        end else if (run) begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    // Each channel sees a differently rotated view to decorrelate dither.
    for (genvar g = 0; g < NCH; g++) begin : g_dither
        assign dither[g*8 +: 8] = 8'(rotr16(lfsr, 3 * g));
    end
`else
    assign dither = '0;
`endif

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        dsmod_mc_ch #(
            .NBIT (NBIT)
        ) u_ch (
            .clk    (i_clk),
            .rst    (i_rst),
            .clear  (clear),
            .run    (run),
            .load   (load),
            .fetch  (fetch),
            .miss   (miss),
            .idle   (idle),
            .mode   (mode_q),
            .shift  (shift),
            .sample (i_data[g*NBIT +: NBIT]),
            .dither (dither[g*8 +: 8]),
            .raw    (raw[g])
        );
    end

    assign o_ds   = raw ^ {NCH{i_out_invert}};
    assign o_ds_n = ~o_ds;

endmodule

// File: tb/tb_dsmod_mc.sv
// Directed self-checking bench for dsmod_mc: reset values, ones density for
// both orders, fetch cadence, underrun handling and mid-run reset.
module tb_dsmod_mc;

    localparam int NBIT = 24;
    localparam int NCH  = 2;

    logic                i_clk = 1'b0;
    logic                i_rst;
    logic                i_ena;
    logic                i_mode;
    logic [1:0]          i_osr;
    logic                i_out_invert;
    logic [NCH*NBIT-1:0] i_data;
    logic                i_valid;
    logic                o_ready;
    logic                o_underrun;
    logic                i_clr_underrun;
    logic [NCH-1:0]      o_ds;
    logic [NCH-1:0]      o_ds_n;

    int checks   = 0;
    int failures = 0;

    logic [NCH-1:0] ds_rec [256];

    dsmod_mc #(
        .NBIT (NBIT),
        .NCH  (NCH)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_ena          (i_ena),
        .i_mode         (i_mode),
        .i_osr          (i_osr),
        .i_out_invert   (i_out_invert),
        .i_data         (i_data),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .o_underrun     (o_underrun),
        .i_clr_underrun (i_clr_underrun),
        .o_ds           (o_ds),
        .o_ds_n         (o_ds_n)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation time limit exceeded");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s did not match", tag);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert ((obs >= lo && obs <= hi) === 1'b1) else begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
            $error("check %s out of range", tag);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge with reset released.
    task automatic do_reset();
        i_rst          = 1'b1;
        i_ena          = 1'b0;
        i_valid        = 1'b0;
        i_clr_underrun = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    // Returns at the first falling edge in RUN (counter just reloaded).
    task automatic start_run(input logic mode, input logic [1:0] osr, input string tag);
        i_mode  = mode;
        i_osr   = osr;
        i_valid = 1'b1;
        i_ena   = 1'b1;
        @(negedge i_clk);
        check({tag, "_prime_ready"}, 32'(o_ready), 32'd1);
        @(negedge i_clk);
    endtask

    initial begin
        logic [NCH-1:0] exp_ds;
        logic [NCH-1:0] nds;
        int             ones0;
        int             ones1;
        int             pulses;

        i_rst          = 1'b1;
        i_ena          = 1'b0;
        i_mode         = 1'b0;
        i_osr          = 2'd0;
        i_out_invert   = 1'b0;
        i_data         = '0;
        i_valid        = 1'b0;
        i_clr_underrun = 1'b0;

        // Reset values before any clock edge.
        #2;
        check("rst_ready", 32'(o_ready), 32'd0);
        check("rst_underrun", 32'(o_underrun), 32'd0);
        check("rst_ds", 32'(o_ds), 32'd0);
        check("rst_ds_n", 32'(o_ds_n), 32'd3);
        @(negedge i_clk);
        i_rst = 1'b0;

        // Zero input, order 1, OSR32: alternating bits, 128 ones in 256.
        start_run(1'b0, 2'd0, "a");
        ones0 = 0;
        ones1 = 0;
        for (int i = 0; i < 256; i++) begin
            ds_rec[i] = o_ds;
            ones0 += int'(o_ds[0]);
            ones1 += int'(o_ds[1]);
            nds = ~o_ds;
            check("a_ds_n", 32'(o_ds_n), 32'(nds));
            @(negedge i_clk);
        end
        check("a_first_bits", 32'(ds_rec[0]), 32'd3);
        check_range("a_ones_ch0", ones0, 127, 129);
        check_range("a_ones_ch1", ones1, 127, 129);

        // Same run with inverted outputs must be the exact complement.
        do_reset();
        i_out_invert = 1'b1;
        start_run(1'b0, 2'd0, "f");
        for (int i = 0; i < 256; i++) begin
            exp_ds = ~ds_rec[i];
            nds    = ~o_ds;
            check("f_inverse", 32'(o_ds), 32'(exp_ds));
            check("f_ds_n", 32'(o_ds_n), 32'(nds));
            @(negedge i_clk);
        end
        i_out_invert = 1'b0;

        // Order 2, OSR64, +/- half scale: 75% and 25% density.
        do_reset();
        i_data = {24'hC00000, 24'h400000};
        start_run(1'b1, 2'd1, "b");
        ones0 = 0;
        ones1 = 0;
        for (int i = 0; i < 4096; i++) begin
            ones0 += int'(o_ds[0]);
            ones1 += int'(o_ds[1]);
            @(negedge i_clk);
        end
        check_range("b_ones_ch0", ones0, 3032, 3112);
        check_range("b_ones_ch1", ones1, 984, 1064);

        // OSR128 with i_valid held: one ready pulse per 128 cycles.
        do_reset();
        i_data = '0;
        start_run(1'b0, 2'd2, "c");
        pulses = 0;
        for (int i = 0; i < 384; i++) begin
            check("c_ready", 32'(o_ready), ((i % 128) == 127) ? 32'd1 : 32'd0);
            pulses += int'(o_ready);
            @(negedge i_clk);
        end
        check("c_pulses", 32'(pulses), 32'd3);

        // Underrun: miss the slot at index 31 of an OSR32 run.
        do_reset();
        i_data = {24'hC00000, 24'h400000};
        start_run(1'b0, 2'd0, "d");
        for (int i = 0; i < 31; i++) @(negedge i_clk);
        check("d_slot_ready", 32'(o_ready), 32'd1);
        i_valid = 1'b0;
        @(negedge i_clk);
        check("d_underrun_set", 32'(o_underrun), 32'd1);
        check("d_ready_low", 32'(o_ready), 32'd0);
        i_valid = 1'b1;
        ones0 = 0;
        ones1 = 0;
        for (int i = 0; i < 32; i++) begin
            check("d_sticky", 32'(o_underrun), 32'd1);
            ones0 += int'(o_ds[0]);
            ones1 += int'(o_ds[1]);
            @(negedge i_clk);
        end
        check_range("d_held_ch0", ones0, 23, 25);
        check_range("d_held_ch1", ones1, 7, 9);
        i_clr_underrun = 1'b1;
        @(negedge i_clk);
        i_clr_underrun = 1'b0;
        check("d_cleared", 32'(o_underrun), 32'd0);

        // Clear and miss in the same cycle: clear wins (slot at index 95).
        for (int i = 0; i < 30; i++) @(negedge i_clk);
        check("d_slot2_ready", 32'(o_ready), 32'd1);
        i_valid        = 1'b0;
        i_clr_underrun = 1'b1;
        @(negedge i_clk);
        i_clr_underrun = 1'b0;
        check("d_clr_wins", 32'(o_underrun), 32'd0);
        for (int i = 0; i < 32; i++) @(negedge i_clk);
        check("d_underrun_again", 32'(o_underrun), 32'd1);

        // Reset mid-RUN takes effect without a clock edge.
        #2;
        i_rst = 1'b1;
        #1;
        check("e_ready", 32'(o_ready), 32'd0);
        check("e_underrun", 32'(o_underrun), 32'd0);
        check("e_ds", 32'(o_ds), 32'd0);
        check("e_ds_n", 32'(o_ds_n), 32'd3);
        i_out_invert = 1'b1;
        #1;
        check("e_ds_inv", 32'(o_ds), 32'd3);
        check("e_ds_n_inv", 32'(o_ds_n), 32'd0);
        i_out_invert = 1'b0;
        @(negedge i_clk);
        i_rst   = 1'b0;
        i_ena   = 1'b1;
        i_valid = 1'b0;
        @(negedge i_clk);
        check("e_prime_ready", 32'(o_ready), 32'd1);
        check("e_prime_underrun", 32'(o_underrun), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
